rename_nwide: RTL

- Parametrised N-wide successor to the single-wide rename stage.
- Each cycle, renames up to WIDTH instructions from decode against a speculative RAT, allocating physical destinations from an internal circular free list.
- Resolves intra-group dependencies and registers results toward IQ/LSQ/ROB dispatch.
- Maintains a committed RAT and committed free-list head so a flush restores precise rename state in one cycle.

---
 rtl/rename_nwide.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rename_nwide.sv
// rename_nwide: WIDTH-lane register rename with speculative/committed RATs and a circular free list.
// Define RENAME_PERF_EN to add saturating stall/rename performance counters.
module rename_nwide #(
   parameter int WIDTH     = 2,
   parameter int ARCH_REGS = 32,
   parameter int PHYS_REGS = 64,
   parameter int AREG_W    = 5,
   parameter int PREG_W    = 6
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [WIDTH-1:0]         in_valid,
   input  logic [WIDTH-1:0]         in_dst_en,
   input  logic [WIDTH*AREG_W-1:0]  in_dst,
   input  logic [WIDTH*AREG_W-1:0]  in_src1,
   input  logic [WIDTH*AREG_W-1:0]  in_src2,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_valid,
   output logic [WIDTH*PREG_W-1:0]  out_pdst,
   output logic [WIDTH*PREG_W-1:0]  out_psrc1,
   output logic [WIDTH*PREG_W-1:0]  out_psrc2,
   output logic [WIDTH*PREG_W-1:0]  out_old_pdst,
   input  logic                     down_ready,
   input  logic [WIDTH-1:0]         commit_valid,
   input  logic [WIDTH-1:0]         commit_dst_en,
   input  logic [WIDTH*AREG_W-1:0]  commit_areg,
   input  logic [WIDTH*PREG_W-1:0]  commit_pdst,
   input  logic [WIDTH*PREG_W-1:0]  commit_old_pdst,
   input  logic                     flush,
   output logic [PREG_W:0]          free_count
`ifdef RENAME_PERF_EN
   ,
   output logic [31:0]              perf_stall_free,
   output logic [31:0]              perf_stall_down,
   output logic [31:0]              perf_renamed
`endif
);

   typedef logic [AREG_W-1:0] areg_t;
   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PREG_W:0]   cnt_t;

   preg_t specRat    [ARCH_REGS];
   preg_t comRat     [ARCH_REGS];
   preg_t comRatNext [ARCH_REGS];
   preg_t freeList   [PHYS_REGS];
   preg_t head, commitHead, tail;
   cnt_t  freeCnt, popCnt, pushCnt;

   logic [WIDTH-1:0] effDst, pushEn;
   preg_t lanePdst  [WIDTH];
   preg_t lanePsrc1 [WIDTH];
   preg_t lanePsrc2 [WIDTH];
   preg_t laneOld   [WIDTH];
   preg_t pushSlot  [WIDTH];
   logic  accept;

   function automatic areg_t aregAt(input logic [WIDTH*AREG_W-1:0] bus, input int lane);
      return bus[lane*AREG_W +: AREG_W];
   endfunction

   function automatic preg_t pregAt(input logic [WIDTH*PREG_W-1:0] bus, input int lane);
      return bus[lane*PREG_W +: PREG_W];
   endfunction

   assign free_count = freeCnt;
   assign in_ready   = !RESET && !flush && (freeCnt >= cnt_t'(WIDTH)) && (!(|out_valid) || down_ready);
   assign accept     = in_ready && (|in_valid);

   // Lanes are resolved oldest-first so a later matching lane overrides the bypass source.
   always_comb begin
      popCnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         effDst[i]    = in_valid[i] && in_dst_en[i] && (aregAt(in_dst, i) != '0);
         lanePdst[i]  = effDst[i] ? freeList[head + popCnt[PREG_W-1:0]] : '0;
         // NOTE: blocking '=' here builds a running count across lanes within one evaluation.
         popCnt       = popCnt + cnt_t'(effDst[i]);
         lanePsrc1[i] = specRat[aregAt(in_src1, i)];
         lanePsrc2[i] = specRat[aregAt(in_src2, i)];
         laneOld[i]   = specRat[aregAt(in_dst, i)];
         for (int k = 0; k < i; k++) begin
            if (effDst[k] && aregAt(in_dst, k) == aregAt(in_src1, i)) lanePsrc1[i] = lanePdst[k];
            if (effDst[k] && aregAt(in_dst, k) == aregAt(in_src2, i)) lanePsrc2[i] = lanePdst[k];
            if (effDst[k] && aregAt(in_dst, k) == aregAt(in_dst, i))  laneOld[i]   = lanePdst[k];
         end
         if (aregAt(in_src1, i) == '0) lanePsrc1[i] = '0;
         if (aregAt(in_src2, i) == '0) lanePsrc2[i] = '0;
         if (aregAt(in_dst, i) == '0)  laneOld[i]   = '0;
      end
   end

   always_comb begin
      comRatNext = comRat;
      pushCnt    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pushEn[i]   = commit_valid[i] && commit_dst_en[i] && (aregAt(commit_areg, i) != '0);
         pushSlot[i] = tail + pushCnt[PREG_W-1:0];
         if (pushEn[i]) comRatNext[aregAt(commit_areg, i)] = pregAt(commit_pdst, i);
         pushCnt     = pushCnt + cnt_t'(pushEn[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int a = 0; a < ARCH_REGS; a++) begin
            specRat[a] <= preg_t'(a);
            comRat[a]  <= preg_t'(a);
         end
         // NOTE: the free list holds live state, so unlike a data buffer it must be initialised on reset.
         for (int p = 0; p < PHYS_REGS; p++) freeList[p] <= preg_t'(ARCH_REGS + p);
         head         <= '0;
         commitHead   <= '0;
         tail         <= preg_t'(PHYS_REGS - ARCH_REGS);
         freeCnt      <= cnt_t'(PHYS_REGS - ARCH_REGS);
         out_valid    <= '0;
         out_pdst     <= '0;
         out_psrc1    <= '0;
         out_psrc2    <= '0;
         out_old_pdst <= '0;
      end else begin
         comRat <= comRatNext;
         for (int i = 0; i < WIDTH; i++)
            if (pushEn[i]) freeList[pushSlot[i]] <= pregAt(commit_old_pdst, i);
         tail       <= tail + pushCnt[PREG_W-1:0];
         commitHead <= commitHead + pushCnt[PREG_W-1:0];
         if (flush) begin
            // Entries between the restored head and old head return to the free pool.
            specRat   <= comRatNext;
            head      <= commitHead + pushCnt[PREG_W-1:0];
            freeCnt   <= freeCnt + pushCnt + {1'b0, head - (commitHead + pushCnt[PREG_W-1:0])};
            out_valid <= '0;
         end else if (accept) begin
            for (int i = 0; i < WIDTH; i++)
               if (effDst[i]) specRat[aregAt(in_dst, i)] <= lanePdst[i];
            head      <= head + popCnt[PREG_W-1:0];
            freeCnt   <= freeCnt + pushCnt - popCnt;
            out_valid <= in_valid;
            for (int i = 0; i < WIDTH; i++) begin
               out_pdst[i*PREG_W +: PREG_W]     <= in_valid[i] ? lanePdst[i]  : '0;
               out_psrc1[i*PREG_W +: PREG_W]    <= in_valid[i] ? lanePsrc1[i] : '0;
               out_psrc2[i*PREG_W +: PREG_W]    <= in_valid[i] ? lanePsrc2[i] : '0;
               out_old_pdst[i*PREG_W +: PREG_W] <= in_valid[i] ? laneOld[i]   : '0;
            end
         end else begin
            if (down_ready) out_valid <= '0;
            freeCnt <= freeCnt + pushCnt;
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         assert (int'(freeCnt) + int'(pushCnt) <= PHYS_REGS + (accept ? int'(popCnt) : 0))
            else $display("rename_nwide: free list overflow at %0t", $time);
      end
   end
`endif

`ifdef RENAME_PERF_EN
   logic [2:0] acceptLanes;

   always_comb begin
      acceptLanes = '0;
      for (int i = 0; i < WIDTH; i++) acceptLanes = acceptLanes + 3'(in_valid[i]);
   end

   function automatic logic [31:0] satAdd(input logic [31:0] cnt, input logic [2:0] inc);
      logic [32:0] sum;
      sum = {1'b0, cnt} + 33'(inc);
      return sum[32] ? '1 : sum[31:0];
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET) begin
         perf_stall_free <= '0;
         perf_stall_down <= '0;
         perf_renamed    <= '0;
      end else begin
         perf_stall_free <= satAdd(perf_stall_free, {2'b0, (|in_valid) && (freeCnt < cnt_t'(WIDTH))});
         perf_stall_down <= satAdd(perf_stall_down, {2'b0, (|out_valid) && !down_ready});
         perf_renamed    <= satAdd(perf_renamed, accept ? acceptLanes : 3'd0);
      end
   end
`endif

endmodule
